// File: rtl/shift_seq_ctrl.sv
// Serial right shift/rotate sequencer: one 1-bit step per clock, amt steps per request.
// Optional SHIFT_EARLY_EXIT_EN ends the operation as soon as a non-rotate result saturates.
module shift_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [AMT_W-1:0] amt,
  input  logic             sra,
  input  logic             rotate,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             rot_q, rot_d;
  logic             sra_q, sra_d;
  logic [WIDTH-1:0] step_val;

  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] r,
                                               input logic rot, input logic ar);
    if (rot)     return {r[0], r[WIDTH-1:1]};
    else if (ar) return {r[WIDTH-1], r[WIDTH-1:1]};
    else         return {1'b0, r[WIDTH-1:1]};
  endfunction

`ifdef SHIFT_EARLY_EXIT_EN
  // Once saturated, further non-rotate steps cannot change the value.
  function automatic logic sat_fn(input logic [WIDTH-1:0] r,
                                  input logic rot, input logic ar);
    if (rot)     return 1'b0;
    else if (ar) return (r == {WIDTH{r[WIDTH-1]}});
    else         return (r == '0);
  endfunction
`endif

  assign step_val = step_fn(r_q, rot_q, sra_q);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    sra_d   = sra_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          r_d   = a_in;
          cnt_d = amt;
          rot_d = rotate;
          sra_d = sra;
          if (amt == '0) state_d = S_DONE;
          else           state_d = S_SHIFT;
`ifdef SHIFT_EARLY_EXIT_EN
          if (sat_fn(a_in, rotate, sra)) state_d = S_DONE;
`endif
        end
      end
      S_SHIFT: begin
        r_d   = step_val;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) state_d = S_DONE;
`ifdef SHIFT_EARLY_EXIT_EN
        if (sat_fn(step_val, rot_q, sra_q)) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      rot_q   <= 1'b0;
      sra_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      sra_q   <= sra_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign result      = r_q;

endmodule
